nearest_hit_sequencer: RTL and testbench
========================================

NEAREST_HIT_SEQUENCER -- requirements
Module: nearest_hit_sequencer

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 4: number of scene objects evaluated per pixel (1..64).
REQ-002 SHALL have parameter EVAL_LAT, default 2: cycles each object index is held before its result is sampled (1..16).
REQ-003 SHALL have parameter DIST_W, default 64: width of distance values.
REQ-004 SHALL have parameter COORD_W, default 10: width of pixel coordinates.
REQ-005 SHALL have parameter MISS_DIST, default all ones at DIST_W: distance reported when no object is hit.
REQ-006 SHALL have parameter MIN_DIST, default 0: near-clip threshold, used only under REQ-030.
REQ-007 Clk  in  1  single system clock; all state on its rising edge.
REQ-008 Reset_n  in  1  asynchronous, active-low reset.
REQ-009 Start  in  1  request to trace one pixel; accepted only in IDLE.
REQ-010 Pixel_X, Pixel_Y  in  COORD_W each  coordinates of the requested pixel, captured with Start.
REQ-011 Collision  in  1  the object at Read_index is hit by the current ray.
REQ-012 Curr_Dist  in  DIST_W  unsigned hit distance for the object at Read_index.
REQ-013 Write_Ready  in  1  frame buffer accepts the pixel this cycle.
REQ-014 Busy  out  1  high in every state except IDLE.
REQ-015 Read_index  out  clog2(NUM_OBJ), min 1  object currently under evaluation.
REQ-016 Write_Pixel  out  1  result valid; held until Write_Ready.
REQ-017 Write_X, Write_Y  out  COORD_W each  captured coordinates.
REQ-018 Best_Dist  out  DIST_W  nearest accepted distance, or MISS_DIST.
REQ-019 Best_index  out  clog2(NUM_OBJ)  index of nearest object; 0 on a miss.
REQ-020 Hit_valid  out  1  at least one object accepted this pixel.

Function
REQ-021 SHALL implement states IDLE, EVAL, WRITE; IDLE->EVAL on Start, EVAL->WRITE after the last object's sample, WRITE->IDLE on Write_Ready.
REQ-022 On Start accept SHALL capture Pixel_X/Pixel_Y, set Best_Dist=MISS_DIST, Best_index=0, Hit_valid=0, Read_index=0, latency counter=0.
REQ-023 In EVAL SHALL hold Read_index for exactly EVAL_LAT cycles; on the clock edge ending the EVAL_LAT-th cycle SHALL sample Collision/Curr_Dist, then advance Read_index by 1 or, at NUM_OBJ-1, enter WRITE.
REQ-024 Sample accepted iff Collision=1 and Curr_Dist < Best_Dist (strict unsigned); accept updates Best_Dist, Best_index, sets Hit_valid.
REQ-025 Ties SHALL retain the lower index; Curr_Dist equal to MISS_DIST SHALL never be accepted.
REQ-026 Write_Pixel SHALL first assert NUM_OBJ*EVAL_LAT+1 cycles after the Start edge; Write_X/Y, Best_* and Hit_valid SHALL be stable while Write_Pixel=1.
REQ-027 Start while Busy=1 SHALL be ignored, including in the cycle Write_Ready is accepted; a new Start is accepted no earlier than the cycle after return to IDLE.
REQ-028 Collision/Curr_Dist SHALL be ignored outside sample edges; outputs SHALL be registered.

Reset
REQ-029 Reset_n=0 SHALL immediately force IDLE, Busy=0, Write_Pixel=0, Read_index=0, Write_X/Y=0, Best_Dist=MISS_DIST, Best_index=0, Hit_valid=0, counter=0, aborting any pixel in progress without a write.

Configuration
REQ-030 Macro NEAR_CLIP_EN: when defined, REQ-024 additionally requires Curr_Dist >= MIN_DIST; when undefined, MIN_DIST is unused and no clip logic exists.

Verification (NUM_OBJ=4, EVAL_LAT=2, DIST_W=64)
REQ-031 Start, Collision=0 throughout, Write_Ready=1 -> Write_Pixel at cycle 9 for one cycle, Hit_valid=0, Best_Dist=all ones, Best_index=0.
REQ-032 All hit, dists 50,30,30,70 -> Best_index=1, Best_Dist=30, Hit_valid=1.
REQ-033 Pixel (639,479), Write_Ready low 5 cycles with Start pulses -> Write_Pixel held 6 cycles, Write_X/Y=639/479 stable, Starts ignored, IDLE after accept.
REQ-034 Reset_n low during object 2 -> all outputs at reset values same cycle, no Write_Pixel; next Start traces normally.
REQ-035 NEAR_CLIP_EN, MIN_DIST=10, dists 5,20,miss,miss -> Best_index=1, Best_Dist=20; without macro -> Best_index=0, Best_Dist=5.

Source files
------------

// File: rtl/nearest_hit_sequencer.sv
// nearest_hit_sequencer: steps through NUM_OBJ scene objects for one pixel,
// holds each object index for EVAL_LAT cycles, keeps the nearest accepted
// hit and presents the result to the frame buffer with a valid/ready hold.
// Optional build macro NEAR_CLIP_EN: rejects hits closer than MIN_DIST.
module nearest_hit_sequencer #(
  parameter int                NUM_OBJ   = 4,
  parameter int                EVAL_LAT  = 2,
  parameter int                DIST_W    = 64,
  parameter int                COORD_W   = 10,
  parameter logic [DIST_W-1:0] MISS_DIST = '1,
  parameter logic [DIST_W-1:0] MIN_DIST  = '0,
  localparam int               IDX_W     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [COORD_W-1:0] Pixel_X,
  input  logic [COORD_W-1:0] Pixel_Y,
  input  logic               Collision,
  input  logic [DIST_W-1:0]  Curr_Dist,
  input  logic               Write_Ready,
  output logic               Busy,
  output logic [IDX_W-1:0]   Read_index,
  output logic               Write_Pixel,
  output logic [COORD_W-1:0] Write_X,
  output logic [COORD_W-1:0] Write_Y,
  output logic [DIST_W-1:0]  Best_Dist,
  output logic [IDX_W-1:0]   Best_index,
  output logic               Hit_valid
);

  localparam int CNT_W = $clog2(EVAL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EVAL_LAT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OBJ - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVAL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Busy is a pure decode of the state register, so it carries no input path.
  assign Busy = (state != S_IDLE);

  // Acceptance test for the sample taken at the end of an object's hold window.
  always_comb begin
    accept = Collision && (Curr_Dist < Best_Dist) && (Curr_Dist != MISS_DIST);
`ifdef NEAR_CLIP_EN
    accept = accept && (Curr_Dist >= MIN_DIST);
`endif
  end

`ifndef NEAR_CLIP_EN
  // Clip threshold has no function in this build; keep it referenced for lint.
  logic unused_min_dist;
  assign unused_min_dist = ^MIN_DIST;
`endif

  // Sequencer: capture on Start, sample once per object, hold result until taken.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      Read_index  <= '0;
      Write_Pixel <= 1'b0;
      Write_X     <= '0;
      Write_Y     <= '0;
      Best_Dist   <= MISS_DIST;
      Best_index  <= '0;
      Hit_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state      <= S_EVAL;
            Write_X    <= Pixel_X;
            Write_Y    <= Pixel_Y;
            Best_Dist  <= MISS_DIST;
            Best_index <= '0;
            Hit_valid  <= 1'b0;
            Read_index <= '0;
            cnt        <= '0;
          end
        end
        S_EVAL: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (accept) begin
              Best_Dist  <= Curr_Dist;
              Best_index <= Read_index;
              Hit_valid  <= 1'b1;
            end
            if (Read_index == IDX_LAST) begin
              state       <= S_WRITE;
              Write_Pixel <= 1'b1;
            end else begin
              Read_index <= Read_index + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WRITE: begin
          // Start is deliberately not looked at here, even on the accept edge.
          if (Write_Ready) begin
            state       <= S_IDLE;
            Write_Pixel <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          Write_Pixel <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nearest_hit_sequencer.sv
// Bench for nearest_hit_sequencer (NUM_OBJ=4, EVAL_LAT=2, DIST_W=64):
// fixed vector table, reset-abort sequence, then random pixels against a model.
module tb_nearest_hit_sequencer;
  localparam int NO = 4;
  localparam int EL = 2;
  localparam int DW = 64;
  localparam int CW = 10;
  localparam logic [DW-1:0] MISS  = '1;
  localparam logic [DW-1:0] MIN_D = 64'd10;

  logic          Clk, Reset_n, Start, Collision, Write_Ready;
  logic [CW-1:0] Pixel_X, Pixel_Y, Write_X, Write_Y;
  logic [DW-1:0] Curr_Dist, Best_Dist;
  logic          Busy, Write_Pixel, Hit_valid;
  logic [1:0]    Read_index, Best_index;

  logic [NO-1:0]         cur_col;
  logic [NO-1:0][DW-1:0] cur_dist;

  int errors = 0;
  int checks = 0;

  nearest_hit_sequencer #(
    .NUM_OBJ(NO), .EVAL_LAT(EL), .DIST_W(DW), .COORD_W(CW),
    .MISS_DIST(MISS), .MIN_DIST(MIN_D)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .Pixel_X(Pixel_X), .Pixel_Y(Pixel_Y),
    .Collision(Collision), .Curr_Dist(Curr_Dist), .Write_Ready(Write_Ready),
    .Busy(Busy), .Read_index(Read_index), .Write_Pixel(Write_Pixel),
    .Write_X(Write_X), .Write_Y(Write_Y), .Best_Dist(Best_Dist),
    .Best_index(Best_index), .Hit_valid(Hit_valid)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Scene model: the evaluator answers for whichever object is being addressed.
  always_comb begin
    Collision = cur_col[Read_index];
    Curr_Dist = cur_dist[Read_index];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit qualifies(input logic c, input logic [DW-1:0] d);
    bit q;
    q = c && (d != MISS);
`ifdef NEAR_CLIP_EN
    q = q && (d >= MIN_D);
`endif
    return q;
  endfunction

  // Reference: minimum over qualifying hits, then the lowest index holding it.
  function automatic void model(input logic [NO-1:0] col, input logic [NO-1:0][DW-1:0] d,
                                output logic [DW-1:0] b, output logic [1:0] ix, output logic h);
    logic [DW-1:0] m;
    m = MISS; h = 1'b0; ix = 2'd0;
    for (int k = 0; k < NO; k++)
      if (qualifies(col[k], d[k])) begin
        h = 1'b1;
        if (d[k] < m) m = d[k];
      end
    b = m;
    if (h)
      for (int k = NO - 1; k >= 0; k--)
        if (qualifies(col[k], d[k]) && d[k] == m) ix = 2'(k);
  endfunction

  task automatic trace(input logic [CW-1:0] x, input logic [CW-1:0] y,
                       input logic [NO-1:0] col, input logic [NO-1:0][DW-1:0] d,
                       input logic [DW-1:0] eb, input logic [1:0] ei, input logic eh,
                       input int stall);
    int c, hold;
    bit idx_bad, out_bad;
    cur_col = col;
    cur_dist = d;
    @(negedge Clk);
    Pixel_X = x; Pixel_Y = y; Start = 1'b1;
    Write_Ready = (stall == 0);
    @(negedge Clk);
    Start = 1'b0;
    Pixel_X = ~x; Pixel_Y = ~y;
    chk("busy_after_start", Busy, 1'b1);
    c = 1; idx_bad = 0;
    while (!Write_Pixel && c < 40) begin
      if (Read_index != 2'((c - 1) / EL)) idx_bad = 1;
      @(negedge Clk);
      c++;
    end
    chk("write_latency", 64'(c), 64'(NO * EL + 1));
    chk("read_index_walk", 64'(idx_bad), 64'd0);
    hold = 0; out_bad = 0;
    while (Write_Pixel && hold < 40) begin
      hold++;
      if (Write_X !== x || Write_Y !== y || Best_Dist !== eb ||
          Best_index !== ei || Hit_valid !== eh || Busy !== 1'b1) out_bad = 1;
      if (stall > 0) Start = 1'b1;
      if (hold > stall) Write_Ready = 1'b1;
      @(negedge Clk);
    end
    Start = 1'b0;
    chk("result_stable", 64'(out_bad), 64'd0);
    chk("best_dist", Best_Dist, eb);
    chk("best_index", Best_index, ei);
    chk("hit_valid", Hit_valid, eh);
    chk("write_xy", {Write_X, Write_Y}, {x, y});
    chk("write_hold_cycles", 64'(hold), 64'(stall + 1));
    chk("idle_after_accept", Busy, 1'b0);
    @(negedge Clk);
    chk("start_ignored_in_write", Busy, 1'b0);
    Write_Ready = 1'b0;
  endtask

  typedef struct {
    logic [CW-1:0]         x, y;
    logic [NO-1:0]         col;
    logic [NO-1:0][DW-1:0] d;
    logic [DW-1:0]         eb;
    logic [1:0]            ei;
    logic                  eh;
    int                    stall;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // x, y, hits, distances (obj3..obj0), expected best/index/hit, ready stall
    tbl[0] = '{10'd1,   10'd2,   4'b0000, {64'd4, 64'd3, 64'd2, 64'd1}, MISS, 2'd0, 1'b0, 0};
    tbl[1] = '{10'd3,   10'd4,   4'b1111, {64'd70, 64'd30, 64'd30, 64'd50}, 64'd30, 2'd1, 1'b1, 0};
    tbl[2] = '{10'd639, 10'd479, 4'b0100, {64'd9, 64'd123, 64'd7, 64'd8}, 64'd123, 2'd2, 1'b1, 5};
`ifdef NEAR_CLIP_EN
    tbl[3] = '{10'd5,   10'd6,   4'b0011, {64'd1, 64'd1, 64'd20, 64'd5}, 64'd20, 2'd1, 1'b1, 0};
`else
    tbl[3] = '{10'd5,   10'd6,   4'b0011, {64'd1, 64'd1, 64'd20, 64'd5}, 64'd5, 2'd0, 1'b1, 0};
`endif
    tbl[4] = '{10'd7,   10'd8,   4'b1111, {MISS, MISS, MISS, MISS}, MISS, 2'd0, 1'b0, 1};
    tbl[5] = '{10'd9,   10'd10,  4'b1111, {64'd19, 64'd19, 64'd19, 64'd19}, 64'd19, 2'd0, 1'b1, 0};
`ifdef NEAR_CLIP_EN
    tbl[6] = '{10'd11,  10'd12,  4'b1000, {64'd10, 64'd2, 64'd2, 64'd2}, 64'd10, 2'd3, 1'b1, 2};
`else
    tbl[6] = '{10'd11,  10'd12,  4'b1000, {64'd0, 64'd2, 64'd2, 64'd2}, 64'd0, 2'd3, 1'b1, 2};
`endif
    tbl[7] = '{10'd1023, 10'd0,  4'b1111, {MISS, MISS, MISS - 64'd1, MISS}, MISS - 64'd1, 2'd1, 1'b1, 0};

    Reset_n = 1'b0; Start = 1'b0; Write_Ready = 1'b0;
    Pixel_X = '0; Pixel_Y = '0; cur_col = '0; cur_dist = '0;
    repeat (2) @(negedge Clk);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_write_pixel", Write_Pixel, 1'b0);
    chk("rst_best_dist", Best_Dist, MISS);
    chk("rst_index_hit", {Read_index, Best_index, Hit_valid}, 5'd0);
    chk("rst_write_xy", {Write_X, Write_Y}, '0);
    Reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      trace(tbl[i].x, tbl[i].y, tbl[i].col, tbl[i].d, tbl[i].eb, tbl[i].ei, tbl[i].eh, tbl[i].stall);

    // Reset while object 2 is under evaluation: abort, no write, clean restart.
    begin
      int w;
      bit wp_seen;
      cur_col = 4'b1111;
      cur_dist = {64'd1, 64'd2, 64'd3, 64'd4};
      Write_Ready = 1'b1;
      @(negedge Clk); Pixel_X = 10'd77; Pixel_Y = 10'd88; Start = 1'b1;
      @(negedge Clk); Start = 1'b0;
      w = 0;
      while (Read_index != 2'd2 && w < 20) begin
        @(negedge Clk);
        w++;
      end
      chk("reach_obj2", 64'(w < 20), 64'd1);
      #2 Reset_n = 1'b0;
      #1;
      chk("abort_busy", Busy, 1'b0);
      chk("abort_write_pixel", Write_Pixel, 1'b0);
      chk("abort_best_dist", Best_Dist, MISS);
      chk("abort_index_hit", {Read_index, Best_index, Hit_valid}, 5'd0);
      chk("abort_write_xy", {Write_X, Write_Y}, '0);
      @(negedge Clk); Reset_n = 1'b1;
      wp_seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge Clk);
        if (Write_Pixel || Busy) wp_seen = 1;
      end
      chk("no_write_after_abort", 64'(wp_seen), 64'd0);
      Write_Ready = 1'b0;
      trace(tbl[1].x, tbl[1].y, tbl[1].col, tbl[1].d, tbl[1].eb, tbl[1].ei, tbl[1].eh, 0);
    end

    // Random pixels; small distance range forces ties, occasional miss sentinel.
    for (int r = 0; r < 40; r++) begin
      logic [NO-1:0]         col;
      logic [NO-1:0][DW-1:0] d;
      logic [DW-1:0]         eb;
      logic [1:0]            ei;
      logic                  eh;
      col = 4'($urandom);
      for (int k = 0; k < NO; k++)
        d[k] = ($urandom_range(0, 9) == 0) ? MISS : 64'($urandom_range(0, 24));
      model(col, d, eb, ei, eh);
      trace(10'($urandom), 10'($urandom), col, d, eb, ei, eh, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
